// File: rtl/computie_bus_initiator.sv
// computie_bus_initiator: single-outstanding bus master running AS/DS/ACK cycles with timeout.
module computie_bus_initiator #(
  parameter int BITWIDTH = 32,
  parameter int TIMEOUT  = 255
) (
  input  logic                cb_clk,
  input  logic                cb_reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_rw,
  input  logic [BITWIDTH-1:0] req_addr,
  input  logic [BITWIDTH-1:0] req_data,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [BITWIDTH-1:0] resp_data,
  output logic                resp_error,
  output logic                cb_addr_strobe,
  output logic                cb_data_strobe,
  output logic                cb_read_write,
  input  logic                cb_data_ack,
  input  logic [BITWIDTH-1:0] cb_ad_in,
  output logic [BITWIDTH-1:0] cb_ad_out,
  output logic                cb_ad_oe,
  output logic                send_receive,
  output logic                addr_oe,
  output logic                data_oe,
  output logic                data_dir
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);
  typedef enum logic [2:0] {IDLE, ADDR, DATA, RELEASE, RESP} state_t;
  state_t state;
  logic [BITWIDTH-1:0] data;
  logic [TW-1:0] timer;
  logic ack_m, ack_s;
  // Outputs take the values of the state being entered, so every bus control is a flop.
  always_ff @(posedge cb_clk or negedge cb_reset) begin
    if (!cb_reset) begin
      state <= IDLE;
      data <= '0;
      timer <= '0;
      ack_m <= 1'b1;
      ack_s <= 1'b1;
      req_ready <= 1'b1;
      resp_valid <= 1'b0;
      resp_data <= '0;
      resp_error <= 1'b0;
      cb_addr_strobe <= 1'b1;
      cb_data_strobe <= 1'b1;
      cb_read_write <= 1'b1;
      cb_ad_out <= '0;
      cb_ad_oe <= 1'b0;
      send_receive <= 1'b0;
      addr_oe <= 1'b1;
      data_oe <= 1'b1;
      data_dir <= 1'b0;
    end else begin
      ack_m <= cb_data_ack;
      ack_s <= ack_m;
      case (state)
        IDLE: if (req_valid) begin
          data <= req_data;
          req_ready <= 1'b0;
          cb_ad_out <= req_addr;
          cb_ad_oe <= 1'b1;
          cb_addr_strobe <= 1'b0;
          cb_read_write <= req_rw;
          send_receive <= 1'b1;
          addr_oe <= 1'b0;
          data_oe <= 1'b1;
          state <= ADDR;
        end
        ADDR: begin
          cb_data_strobe <= 1'b0;
          addr_oe <= 1'b1;
          data_oe <= 1'b0;
          timer <= TW'(1);
          cb_ad_out <= cb_read_write ? cb_ad_out : data;
          cb_ad_oe <= !cb_read_write;
          data_dir <= !cb_read_write;
          send_receive <= !cb_read_write;
          state <= DATA;
        end
        DATA: if (!ack_s || timer == TMAX) begin
          resp_error <= ack_s;
          resp_data <= (!ack_s && cb_read_write) ? cb_ad_in : '0;
          cb_addr_strobe <= 1'b1;
          cb_data_strobe <= 1'b1;
          cb_ad_oe <= 1'b0;
          addr_oe <= 1'b1;
          data_oe <= 1'b1;
          send_receive <= 1'b0;
          data_dir <= 1'b0;
          timer <= '0;
          state <= RELEASE;
        end else begin
          timer <= timer + TW'(1);
        end
        RELEASE: if (ack_s || timer == TMAX) begin
          resp_error <= resp_error || !ack_s;
          resp_data <= ack_s ? resp_data : '0;
          resp_valid <= 1'b1;
          state <= RESP;
        end else begin
          timer <= timer + TW'(1);
        end
        RESP: if (resp_ready) begin
          resp_valid <= 1'b0;
          req_ready <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_computie_bus_initiator.sv
// tb_computie_bus_initiator: directed and randomized checks against a transaction-level responder model.
module tb_computie_bus_initiator;
  localparam int W = 32;
  localparam int TO = 8;
  logic cb_clk = 0, cb_reset = 0;
  logic req_valid = 0, req_rw = 0, resp_ready = 0;
  logic [W-1:0] req_addr = '0, req_data = '0;
  logic req_ready, resp_valid, resp_error;
  logic [W-1:0] resp_data, cb_ad_out;
  logic cb_addr_strobe, cb_data_strobe, cb_read_write, cb_ad_oe, send_receive, addr_oe, data_oe, data_dir;
  logic cb_data_ack = 1;
  logic [W-1:0] cb_ad_in = '0;
  int checks = 0, errors = 0;
  int ack_delay = -1;
  bit ack_stuck = 0;
  logic [W-1:0] rd_val = '0;
  int ds_cnt = 0;

  computie_bus_initiator #(.BITWIDTH(W), .TIMEOUT(TO)) dut (
    .cb_clk(cb_clk), .cb_reset(cb_reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_rw(req_rw), .req_addr(req_addr), .req_data(req_data), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_data(resp_data), .resp_error(resp_error),
    .cb_addr_strobe(cb_addr_strobe), .cb_data_strobe(cb_data_strobe), .cb_read_write(cb_read_write),
    .cb_data_ack(cb_data_ack), .cb_ad_in(cb_ad_in), .cb_ad_out(cb_ad_out), .cb_ad_oe(cb_ad_oe),
    .send_receive(send_receive), .addr_oe(addr_oe), .data_oe(data_oe), .data_dir(data_dir)
  );

  always #5 cb_clk = ~cb_clk;

  // Responder: acks ack_delay cycles into DS low (never if negative), releases once DS rises.
  always @(negedge cb_clk) begin
    if (!cb_data_strobe) begin
      ds_cnt++;
      if (ack_delay >= 0 && ds_cnt > ack_delay) begin
        cb_data_ack = 0;
        cb_ad_in = rd_val;
      end
    end else begin
      ds_cnt = 0;
      if (!ack_stuck) begin
        cb_data_ack = 1;
        cb_ad_in = ~rd_val;
      end
    end
  end

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic rw, input logic [W-1:0] a, input logic [W-1:0] d);
    bit ok;
    ok = 0;
    @(negedge cb_clk);
    req_valid = 1; req_rw = rw; req_addr = a; req_data = d;
    for (int i = 0; i < 200 && !ok; i++) begin
      if (req_ready) begin
        @(posedge cb_clk);
        ok = 1;
      end else @(negedge cb_clk);
    end
    chk("accept", W'(ok), W'(1));
    @(negedge cb_clk);
    req_valid = 0;
  endtask

  task automatic get_resp(input int hold, output logic [W-1:0] d, output logic e, output int lat);
    lat = 0;
    while (!resp_valid && lat < 100) begin
      @(negedge cb_clk);
      lat++;
    end
    chk("resp_valid", W'(resp_valid), W'(1));
    d = resp_data;
    e = resp_error;
    repeat (hold) @(negedge cb_clk);
    resp_ready = 1;
    @(posedge cb_clk);
    #1 resp_ready = 0;
    chk("resp_drop", W'(resp_valid), W'(0));
  endtask

  initial begin
    logic [W-1:0] d, a, wd, hold_d;
    logic e, rw, exp_e;
    int lat, cnt;
    #12;
    chk("rst_req_ready", W'(req_ready), W'(1));
    chk("rst_resp_valid", W'(resp_valid), W'(0));
    chk("rst_strobes", W'({cb_addr_strobe, cb_data_strobe, cb_read_write}), W'(3'b111));
    chk("rst_bus", cb_ad_out, '0);
    chk("rst_xcvr", W'({cb_ad_oe, send_receive, addr_oe, data_oe, data_dir}), W'(5'b00110));
    @(negedge cb_clk) cb_reset = 1;

    // Write with ack two cycles into DS
    ack_delay = 2;
    send(0, 32'h0000_1000, 32'hDEAD_BEEF);
    chk("wr_as", W'({cb_addr_strobe, cb_data_strobe, cb_ad_oe, cb_read_write}), W'(4'b0110));
    chk("wr_addr", cb_ad_out, 32'h0000_1000);
    chk("wr_addr_xcvr", W'({send_receive, addr_oe, data_oe}), W'(3'b101));
    @(negedge cb_clk);
    chk("wr_ds", W'({cb_addr_strobe, cb_data_strobe, cb_ad_oe, data_dir}), W'(4'b0011));
    chk("wr_data", cb_ad_out, 32'hDEAD_BEEF);
    chk("wr_data_xcvr", W'({addr_oe, data_oe}), W'(2'b10));
    get_resp(0, d, e, lat);
    chk("wr_err", W'(e), W'(0));
    chk("wr_rdata", d, '0);

    // Read with immediate ack: minimum latency
    ack_delay = 0; rd_val = 32'h1234_5678;
    send(1, 32'h0020_0004, 32'hFFFF_FFFF);
    chk("rd_addr", cb_ad_out, 32'h0020_0004);
    @(negedge cb_clk);
    chk("rd_no_drive", W'({cb_ad_oe, send_receive, data_dir, cb_read_write, cb_data_strobe}), W'(5'b00010));
    get_resp(0, d, e, lat);
    chk("rd_latency", W'(lat + 1), W'(7));
    chk("rd_data", d, 32'h1234_5678);
    chk("rd_err", W'(e), W'(0));

    // No ack: DS low for exactly TIMEOUT cycles
    ack_delay = -1;
    send(1, 32'h0000_0040, '0);
    cnt = 0;
    for (int i = 0; i < 40 && !resp_valid; i++) begin
      @(negedge cb_clk);
      if (!cb_data_strobe) cnt++;
    end
    chk("to_ds_cycles", W'(cnt), W'(TO));
    get_resp(0, d, e, lat);
    chk("to_err", W'(e), W'(1));
    chk("to_data", d, '0);

    // Backpressure with a second request waiting
    ack_delay = 1; rd_val = 32'hA5A5_0F0F;
    send(1, 32'h0000_0100, '0);
    cnt = 0;
    while (!resp_valid && cnt < 100) begin
      @(negedge cb_clk);
      cnt++;
    end
    hold_d = resp_data;
    chk("bp_data", hold_d, 32'hA5A5_0F0F);
    req_valid = 1; req_rw = 0; req_addr = 32'h0000_0200; req_data = 32'h1111_2222;
    for (int i = 0; i < 10; i++) begin
      @(negedge cb_clk);
      chk("bp_hold", W'({resp_valid, req_ready, cb_addr_strobe}), W'(3'b101));
      chk("bp_stable", resp_data, hold_d);
    end
    resp_ready = 1;
    @(posedge cb_clk);
    #1 resp_ready = 0;
    chk("bp_release", W'({resp_valid, req_ready, cb_addr_strobe}), W'(3'b011));
    @(posedge cb_clk);
    #1 req_valid = 0;
    chk("bp_accept", W'({req_ready, cb_addr_strobe}), W'(2'b00));
    chk("bp_addr", cb_ad_out, 32'h0000_0200);
    get_resp(0, d, e, lat);
    chk("bp_wr_err", W'(e), W'(0));

    // Ack stuck low after a read: release timeout
    ack_stuck = 1; ack_delay = 0; rd_val = 32'hCAFE_F00D;
    send(1, 32'h0000_0300, '0);
    get_resp(0, d, e, lat);
    chk("stuck_err", W'(e), W'(1));
    chk("stuck_data", d, '0);
    ack_stuck = 0;
    repeat (4) @(negedge cb_clk);

    // Reset during write DATA
    ack_delay = -1;
    send(0, 32'h0000_0400, 32'h5555_AAAA);
    @(negedge cb_clk);
    chk("rs_in_data", W'(cb_data_strobe), W'(0));
    #2 cb_reset = 0;
    #1;
    chk("rs_strobes", W'({cb_addr_strobe, cb_data_strobe, cb_ad_oe}), W'(3'b110));
    chk("rs_xcvr", W'({addr_oe, data_oe, req_ready, resp_valid}), W'(4'b1110));
    @(negedge cb_clk) cb_reset = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge cb_clk);
      chk("rs_idle", W'({req_ready, resp_valid, cb_data_strobe}), W'(3'b101));
    end

    // Randomized transactions against the response-level model
    for (int n = 0; n < 24; n++) begin
      int dsel;
      rw = 1'($urandom_range(0, 1));
      a = $urandom; wd = $urandom; rd_val = $urandom;
      dsel = $urandom_range(0, 4);
      ack_delay = (dsel == 4) ? -1 : dsel;
      exp_e = (ack_delay < 0);
      send(rw, a, wd);
      chk("rnd_addr", cb_ad_out, a);
      get_resp($urandom_range(0, 3), d, e, lat);
      chk("rnd_err", W'(e), W'(exp_e));
      chk("rnd_data", d, (rw && !exp_e) ? rd_val : '0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/computie_bus_initiator.md
Name: computie_bus_initiator

Overview:
Active bus master for the computie bus, the driving end of the cycles the snooper records. It accepts one read or write request at a time on a valid/ready command interface. It runs a complete address-strobe / data-strobe / data-acknowledge cycle on the multiplexed address/data bus, then returns read data or a timeout error on a valid/ready response interface. It also drives the board transceiver controls so that the FPGA sources the bus during its own cycles.

Parameters:
BITWIDTH, 32, width of multiplexed address/data bus and of request/response data
TIMEOUT, 255, max cb_clk cycles waiting for ack assertion or release before aborting (>=2)

Ports:
cb_clk  input  1  bus clock, all logic on posedge
cb_reset  input  1  asynchronous reset, active-low
req_valid  input  1  request present
req_ready  output  1  initiator can accept request
req_rw  input  1  1=read, 0=write
req_addr  input  BITWIDTH  cycle address
req_data  input  BITWIDTH  write data (ignored for reads)
resp_valid  output  1  response present
resp_ready  input  1  response consumer accepts
resp_data  output  BITWIDTH  captured read data (0 for writes)
resp_error  output  1  1=cycle timed out
cb_addr_strobe  output  1  active-low address strobe
cb_data_strobe  output  1  active-low data strobe
cb_read_write  output  1  1=read, 0=write
cb_data_ack  input  1  active-low acknowledge from responder
cb_ad_in  input  BITWIDTH  bus value from pad
cb_ad_out  output  BITWIDTH  value to drive on bus
cb_ad_oe  output  1  1=pad drives cb_ad_out
send_receive  output  1  1=send, 0=receive
addr_oe  output  1  active-low address transceiver enable
data_oe  output  1  active-low data transceiver enable
data_dir  output  1  1=toward bus, 0=from bus

Behaviour:
- Reset (cb_reset low, async): state IDLE; req_ready=1; resp_valid=0; resp_data=0; resp_error=0; strobes=1; cb_read_write=1; cb_ad_oe=0; cb_ad_out=0; send_receive=0; addr_oe=1; data_oe=1; data_dir=0; timer=0. A reset mid-cycle drops all strobes and bus drive immediately; the request is lost and no response is produced.
- All outputs registered; cb_data_ack sampled with a 2-flop synchroniser (ack_s), so ack reaction latency is 2-3 cycles.
- States:
  - IDLE: req_ready=1. Accept on req_valid&req_ready. Latch rw/addr/data. req_ready<=0, go ADDR.
  - ADDR (exactly 1 cycle): cb_ad_out=addr, cb_ad_oe=1, cb_addr_strobe=0, cb_read_write=rw, send_receive=1, addr_oe=0, data_oe=1. Go DATA.
  - DATA: cb_addr_strobe stays 0; cb_data_strobe=0; addr_oe=1; data_oe=0.
    - Write: cb_ad_out=data, cb_ad_oe=1, data_dir=1.
    - Read: cb_ad_oe=0, data_dir=0, send_receive=0.
    - Timer increments each cycle. On ack_s==0: read latches cb_ad_in into resp_data (write sets resp_data=0), resp_error=0, go RELEASE. On timer==TIMEOUT before ack: resp_error=1, resp_data=0, go RELEASE.
  - RELEASE: both strobes=1, cb_ad_oe=0, addr_oe=1, data_oe=1, send_receive=0, data_dir=0. Timer restarts at 0. Go RESP when ack_s==1 or timer==TIMEOUT. In the release-timeout case resp_error=1 and a read result is discarded (resp_data=0).
  - RESP: resp_valid=1 and resp fields stable until resp_ready is sampled high. Then resp_valid<=0, req_ready<=1, go IDLE.
- No overlap: a new request is accepted only after the prior response is consumed. Minimum cycle from acceptance to resp_valid with immediate ack and release is 7 cycles.
- Bus is never driven in IDLE, RELEASE or RESP, and never in DATA for a read.
- Timer width is clog2(TIMEOUT+1); it saturates and cannot wrap.

Test Plan:
- Write: req addr=0x00001000, data=0xDEADBEEF, rw=0; responder acks 2 cycles after DS low -> AS low with bus=0x00001000 for 1 cycle, then DS low with bus=0xDEADBEEF, data_dir=1; response error=0, data=0.
- Read: req addr=0x00200004, rw=1; responder drives 0x12345678 with ack -> cb_ad_oe=0 during DATA; resp_data=0x12345678, error=0.
- Timeout: TIMEOUT=8, no ack -> DS held low exactly 8 cycles then released; resp_error=1, resp_data=0.
- Backpressure: resp_ready held low 10 cycles -> resp_valid and data stable throughout; req_ready stays 0; second req_valid not accepted until cycle after resp_ready.
- Ack stuck low after read -> RELEASE times out; resp_error=1, resp_data=0.
- Reset asserted during DATA of a write -> same-cycle strobes=1, cb_ad_oe=0; after release, state IDLE, req_ready=1, no resp_valid.
